// File: rtl/rysy_mem_bridge.sv
// Arbitrating fetch/load-store bridge onto one req/ack memory bus with lane steering and bus timeout.
// Optional macro RYSY_MISALIGN_CHECK_EN turns misaligned accesses into error responses.
module rysy_mem_bridge #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int PRIO_DATA = 1,
  parameter int TIMEOUT   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_err,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [1:0]          d_size,
  input  logic                d_uns,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   wdata,
  output logic                we,
  output logic [DATA_W/8-1:0] be,
  output logic                req,
  input  logic                ack,
  input  logic [DATA_W-1:0]   rdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int LB    = $clog2(BE_W);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
`ifdef RYSY_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, BUS_I, BUS_D, RESP} state_t;
  state_t state, state_nx;

  logic              live, last_d, owner_d, pick_d, start;
  logic [ADDR_W-1:0] l_addr;
  logic [BE_W-1:0]   l_be, d_bmask;
  logic [DATA_W-1:0] l_wdata, r_data, load_val, sh, lmask, msb;
  logic              l_we, l_uns, l_mis, r_err, abort, timed_out, d_mis, i_mis;
  logic [1:0]        l_size;
  logic [LB-1:0]     l_lane, d_lane, i_lane, d_low_mask;
  logic [CNT_W-1:0]  cnt;
  int unsigned       bits;

  // Lane bits below the access size are dropped (or flagged when checking is enabled).
  always_comb begin
    d_low_mask = '0;
    d_bmask    = '0;
    case (d_size)
      2'd0:    begin d_low_mask = '0;      d_bmask = BE_W'(1);  end
      2'd1:    begin d_low_mask = LB'(1);  d_bmask = BE_W'(3);  end
      2'd2:    begin d_low_mask = LB'(3);  d_bmask = BE_W'(15); end
      default: begin d_low_mask = '1;      d_bmask = '1;        end
    endcase
    d_lane = d_addr[LB-1:0] & ~d_low_mask;
    d_mis  = MIS_EN && ((d_addr[LB-1:0] & d_low_mask) != '0);
    i_lane = '0;
    if (DATA_W == 64) i_lane[LB-1] = i_addr[2];
    i_mis  = MIS_EN && (i_addr[1:0] != 2'b00);
  end

  always_comb begin
    pick_d = d_req;
    if (PRIO_DATA == 0 && i_req && d_req) pick_d = ~last_d;
    start     = (state == IDLE) && live && (i_req || d_req);
    timed_out = (TIMEOUT > 0) && (cnt == CNT_W'(TIMEOUT));
    abort     = l_mis || timed_out;
  end

  // Fetches are latched as unsigned word loads so one extractor serves both channels.
  always_comb begin
    sh    = rdata >> {l_lane, 3'b000};
    bits  = 32'd8 << l_size;
    lmask = '1;
    if (bits < DATA_W) lmask = ~({DATA_W{1'b1}} << bits);
    msb      = lmask & ~(lmask >> 1);
    load_val = sh & lmask;
    if (!l_uns && |(sh & msb)) load_val = load_val | ~lmask;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      live    <= 1'b0;
      last_d  <= 1'b0;
      owner_d <= 1'b0;
      l_addr  <= '0;
      l_be    <= '0;
      l_wdata <= '0;
      l_we    <= 1'b0;
      l_size  <= '0;
      l_uns   <= 1'b0;
      l_lane  <= '0;
      l_mis   <= 1'b0;
      cnt     <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      state <= state_nx;
      live  <= 1'b1;
      if (start) begin
        owner_d <= pick_d;
        last_d  <= pick_d;
        cnt     <= '0;
        if (pick_d) begin
          l_addr  <= {d_addr[ADDR_W-1:LB], {LB{1'b0}}};
          l_we    <= d_we;
          l_size  <= d_size;
          l_uns   <= d_uns;
          l_lane  <= d_lane;
          l_be    <= d_bmask << d_lane;
          l_wdata <= d_wdata << {d_lane, 3'b000};
          l_mis   <= d_mis;
        end else begin
          l_addr  <= {i_addr[ADDR_W-1:LB], {LB{1'b0}}};
          l_we    <= 1'b0;
          l_size  <= 2'd2;
          l_uns   <= 1'b1;
          l_lane  <= i_lane;
          l_be    <= BE_W'(15) << i_lane;
          l_wdata <= '0;
          l_mis   <= i_mis;
        end
      end else if (state == BUS_I || state == BUS_D) begin
        if (abort) begin
          r_data <= '0;
          r_err  <= 1'b1;
        end else if (ack) begin
          r_data <= l_we ? '0 : load_val;
          r_err  <= 1'b0;
        end
        if (!ack) cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // A misaligned access still spends one bus-state cycle with req held low.
  always_comb begin
    state_nx = state;
    i_gnt    = 1'b0;
    d_gnt    = 1'b0;
    i_rvalid = 1'b0;
    d_rvalid = 1'b0;
    i_rdata  = '0;
    d_rdata  = '0;
    i_err    = 1'b0;
    d_err    = 1'b0;
    req      = 1'b0;
    we       = 1'b0;
    addr     = '0;
    be       = '0;
    wdata    = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          d_gnt    = pick_d;
          i_gnt    = ~pick_d;
          state_nx = pick_d ? BUS_D : BUS_I;
        end
      end
      BUS_I, BUS_D: begin
        if (abort) begin
          state_nx = RESP;
        end else begin
          req   = 1'b1;
          addr  = l_addr;
          we    = l_we;
          be    = l_be;
          wdata = l_wdata;
          if (ack) state_nx = RESP;
        end
      end
      RESP: begin
        state_nx = IDLE;
        if (owner_d) begin
          d_rvalid = 1'b1;
          d_rdata  = r_data;
          d_err    = r_err;
        end else begin
          i_rvalid = 1'b1;
          i_rdata  = r_data;
          i_err    = r_err;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rysy_mem_bridge.sv
// Randomized self-checking bench for rysy_mem_bridge (DATA_W=32, TIMEOUT=4; one priority and one round-robin instance).
module tb_rysy_mem_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_we, d_uns, ack;
  logic [31:0] i_addr, d_addr, d_wdata, rdata;
  logic [1:0]  d_size;

  logic        i_gnt_p, i_rvalid_p, i_err_p, d_gnt_p, d_rvalid_p, d_err_p, we_p, req_p;
  logic [31:0] i_rdata_p, d_rdata_p, addr_p, wdata_p;
  logic [3:0]  be_p;
  logic        i_gnt_r, i_rvalid_r, i_err_r, d_gnt_r, d_rvalid_r, d_err_r, we_r, req_r;
  logic [31:0] i_rdata_r, d_rdata_r, addr_r, wdata_r;
  logic [3:0]  be_r;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rysy_mem_bridge #(.DATA_W(32), .ADDR_W(32), .PRIO_DATA(1), .TIMEOUT(4)) dut_p (
    .clk(clk), .rst(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt_p), .i_rvalid(i_rvalid_p),
    .i_rdata(i_rdata_p), .i_err(i_err_p),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_uns(d_uns), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt_p), .d_rvalid(d_rvalid_p), .d_rdata(d_rdata_p),
    .d_err(d_err_p), .addr(addr_p), .wdata(wdata_p), .we(we_p), .be(be_p),
    .req(req_p), .ack(ack), .rdata(rdata)
  );

  rysy_mem_bridge #(.DATA_W(32), .ADDR_W(32), .PRIO_DATA(0), .TIMEOUT(4)) dut_r (
    .clk(clk), .rst(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt_r), .i_rvalid(i_rvalid_r),
    .i_rdata(i_rdata_r), .i_err(i_err_r),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_uns(d_uns), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt_r), .d_rvalid(d_rvalid_r), .d_rdata(d_rdata_r),
    .d_err(d_err_r), .addr(addr_r), .wdata(wdata_r), .we(we_r), .be(be_r),
    .req(req_r), .ack(ack), .rdata(rdata)
  );

  // Reference arithmetic: lane, byte enables, shifted store data, extended load data.
  function automatic int m_lane(input logic [31:0] a, input logic [1:0] sz);
    int l;
    l = int'(a % 4);
    return l - (l % (1 << sz));
  endfunction

  function automatic logic [3:0] m_be(input logic [31:0] a, input logic [1:0] sz);
    logic [63:0] m;
    m = ((64'd1 << (1 << sz)) - 64'd1) << m_lane(a, sz);
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] a, input logic [1:0] sz,
                                          input logic [31:0] wd);
    logic [63:0] v;
    v = {32'd0, wd} << (8 * m_lane(a, sz));
    return v[31:0];
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] sz,
                                         input logic uns, input logic [31:0] rd);
    logic [63:0] v;
    int n;
    n = 8 << sz;
    if (n > 32) n = 32;
    v = {32'd0, rd} >> (8 * m_lane(a, sz));
    v = v % (64'd1 << n);
    if (!uns && v >= (64'd1 << (n - 1))) v = v - (64'd1 << n);
    return v[31:0];
  endfunction

  // Drives one data access on the shared inputs and records what dut_p did.
  task automatic run_data(input logic we_i, input logic [1:0] sz, input logic uns_i,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] bus_rd,
                          input int waits, output logic gnt_o, output logic [31:0] baddr,
                          output logic [3:0] bbe, output logic bwe, output logic [31:0] bwd,
                          output int reqcnt, output int lat, output logic [31:0] rd,
                          output logic err);
    gnt_o = 1'b0; baddr = '0; bbe = '0; bwe = 1'b0; bwd = '0;
    reqcnt = 0; lat = -1; rd = '0; err = 1'b0;
    @(negedge clk);
    d_req = 1'b1; d_we = we_i; d_size = sz; d_uns = uns_i; d_addr = a; d_wdata = wd; ack = 1'b0;
    #1 gnt_o = d_gnt_p;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(negedge clk);
      d_req = 1'b0; d_addr = $urandom; d_wdata = $urandom;
      d_size = 2'($urandom); d_we = 1'($urandom); d_uns = 1'($urandom);
      ack = (c == waits + 1);
      rdata = ack ? bus_rd : $urandom;
      #1;
      if (req_p) reqcnt++;
      if (req_p && ack) begin
        baddr = addr_p; bbe = be_p; bwe = we_p; bwd = wdata_p;
      end
      if (d_rvalid_p) begin
        lat = c; rd = d_rdata_p; err = d_err_p;
      end
    end
    ack = 1'b0;
  endtask

  task automatic run_fetch(input logic [31:0] a, input logic [31:0] bus_rd, input int waits,
                           output logic gnt_o, output logic [31:0] baddr, output logic [3:0] bbe,
                           output logic bwe, output int lat, output logic [31:0] rd,
                           output logic err);
    gnt_o = 1'b0; baddr = '0; bbe = '0; bwe = 1'b1; lat = -1; rd = '0; err = 1'b1;
    @(negedge clk);
    i_req = 1'b1; i_addr = a; ack = 1'b0;
    #1 gnt_o = i_gnt_p;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(negedge clk);
      i_req = 1'b0; i_addr = $urandom;
      ack = (c == waits + 1);
      rdata = ack ? bus_rd : $urandom;
      #1;
      if (req_p && ack) begin
        baddr = addr_p; bbe = be_p; bwe = we_p;
      end
      if (i_rvalid_p) begin
        lat = c; rd = i_rdata_p; err = i_err_p;
      end
    end
    ack = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; i_req = 1'b1; d_req = 1'b1; ack = 1'b1;
    d_we = 1'b0; d_size = 2'd2; d_uns = 1'b0; d_addr = '0; d_wdata = '0; i_addr = '0; rdata = '0;
    #3;
    tests++;
    if ({d_gnt_p, i_gnt_p, req_p, be_p, d_rvalid_p, i_rvalid_p} !== 10'd0) begin
      fails++;
      $display("FAIL reset_outputs_p: got gnt=%b%b req=%b be=%h rv=%b%b expected all 0",
               d_gnt_p, i_gnt_p, req_p, be_p, d_rvalid_p, i_rvalid_p);
    end
    tests++;
    if ({d_gnt_r, i_gnt_r, req_r, addr_r} !== 35'd0) begin
      fails++;
      $display("FAIL reset_outputs_r: got gnt=%b%b req=%b addr=%h expected all 0",
               d_gnt_r, i_gnt_r, req_r, addr_r);
    end
    @(negedge clk);
    i_req = 1'b0; d_req = 1'b0; ack = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_directed;
    logic g, bwe, err; logic [31:0] ba, bwd, rd; logic [3:0] bbe; int rc, lat;
    run_data(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80AABBCC, 0, g, ba, bbe, bwe, bwd, rc, lat, rd, err);
    tests++;
    if ({g, ba, bbe, bwe} !== {1'b1, 32'h100, 4'b1000, 1'b0}) begin
      fails++;
      $display("FAIL lb_bus: got gnt=%b addr=%h be=%b we=%b expected 1 00000100 1000 0", g, ba, bbe, bwe);
    end
    tests++;
    if (lat != 2 || rd !== 32'hFFFFFF80 || err !== 1'b0) begin
      fails++;
      $display("FAIL lb_resp: got lat=%0d data=%h err=%b expected 2 ffffff80 0", lat, rd, err);
    end
    run_data(1'b1, 2'd1, 1'b0, 32'h202, 32'h1234, 32'hDEADBEEF, 0, g, ba, bbe, bwe, bwd, rc, lat, rd, err);
    tests++;
    if ({ba, bbe, bwe, bwd} !== {32'h200, 4'b1100, 1'b1, 32'h12340000}) begin
      fails++;
      $display("FAIL sh_bus: got addr=%h be=%b we=%b wdata=%h expected 00000200 1100 1 12340000",
               ba, bbe, bwe, bwd);
    end
    tests++;
    if (lat != 2 || rd !== 32'h0) begin
      fails++;
      $display("FAIL sh_resp: got lat=%0d data=%h expected 2 00000000", lat, rd);
    end
  endtask

  task automatic test_random_data;
    logic g, bwe, err, w, u; logic [31:0] ba, bwd, rd, a, wd, brd; logic [3:0] bbe;
    logic [1:0] sz; int rc, lat, waits;
    for (int n = 0; n < 30; n++) begin
      w = 1'($urandom); u = 1'($urandom); sz = 2'($urandom_range(0, 2));
      a = $urandom; wd = $urandom; brd = $urandom; waits = $urandom_range(0, 3);
`ifdef RYSY_MISALIGN_CHECK_EN
      a = a & ~((32'd1 << sz) - 32'd1);
`endif
      run_data(w, sz, u, a, wd, brd, waits, g, ba, bbe, bwe, bwd, rc, lat, rd, err);
      tests++;
      if (g !== 1'b1 || lat != waits + 2 || err !== 1'b0) begin
        fails++;
        $display("FAIL rand_timing[%0d]: got gnt=%b lat=%0d err=%b expected 1 %0d 0", n, g, lat, err, waits + 2);
      end
      tests++;
      if (ba !== {a[31:2], 2'b00} || bbe !== m_be(a, sz) || bwe !== w) begin
        fails++;
        $display("FAIL rand_bus[%0d]: got addr=%h be=%b we=%b expected %h %b %b",
                 n, ba, bbe, bwe, {a[31:2], 2'b00}, m_be(a, sz), w);
      end
      tests++;
      if (w ? (bwd !== m_wdata(a, sz, wd) || rd !== 32'h0) : (rd !== m_load(a, sz, u, brd))) begin
        fails++;
        $display("FAIL rand_data[%0d]: got wdata=%h rdata=%h expected wdata=%h rdata=%h (we=%b)",
                 n, bwd, rd, m_wdata(a, sz, wd), w ? 32'h0 : m_load(a, sz, u, brd), w);
      end
    end
  endtask

  task automatic test_fetch;
    logic g, bwe, err; logic [31:0] ba, rd, a, brd; logic [3:0] bbe; int lat, waits;
    for (int n = 0; n < 8; n++) begin
      a = $urandom; brd = $urandom; waits = $urandom_range(0, 3);
`ifdef RYSY_MISALIGN_CHECK_EN
      a[1:0] = 2'b00;
`endif
      run_fetch(a, brd, waits, g, ba, bbe, bwe, lat, rd, err);
      tests++;
      if (g !== 1'b1 || ba !== {a[31:2], 2'b00} || bbe !== 4'hF || bwe !== 1'b0) begin
        fails++;
        $display("FAIL fetch_bus[%0d]: got gnt=%b addr=%h be=%h we=%b expected 1 %h f 0",
                 n, g, ba, bbe, bwe, {a[31:2], 2'b00});
      end
      tests++;
      if (lat != waits + 2 || rd !== brd || err !== 1'b0) begin
        fails++;
        $display("FAIL fetch_resp[%0d]: got lat=%0d data=%h err=%b expected %0d %h 0",
                 n, lat, rd, err, waits + 2, brd);
      end
    end
  endtask

  task automatic test_priority;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) begin
        i_req = 1'b1; i_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = 32'h80;
      end
      if (k == 1) d_req = 1'b0;
      if (k == 4) i_req = 1'b0;
      ack = (k == 1 || k == 4);
      rdata = $urandom;
      #1;
      tests++;
      if ({d_gnt_p, i_gnt_p} !== {k == 0, k == 3}) begin
        fails++;
        $display("FAIL prio_gnt[c%0d]: got d_gnt=%b i_gnt=%b expected %b %b", k, d_gnt_p, i_gnt_p, k == 0, k == 3);
      end
      tests++;
      if ({d_rvalid_p, i_rvalid_p} !== {k == 2, k == 5}) begin
        fails++;
        $display("FAIL prio_rvalid[c%0d]: got d=%b i=%b expected %b %b", k, d_rvalid_p, i_rvalid_p, k == 2, k == 5);
      end
    end
    ack = 1'b0;
  endtask

  task automatic test_round_robin;
    logic exp_d;
    @(negedge clk);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) begin
        i_req = 1'b1; d_req = 1'b1; ack = 1'b1; i_addr = 32'h500; d_addr = 32'h600;
        d_we = 1'b0; d_size = 2'd2; rdata = $urandom;
      end
      if (k == 11) begin
        i_req = 1'b0; d_req = 1'b0;
      end
      #1;
      if (k % 3 == 0) begin
        exp_d = ((k / 3) % 2 == 0);
        tests++;
        if ({d_gnt_r, i_gnt_r} !== {exp_d, !exp_d}) begin
          fails++;
          $display("FAIL rr_gnt[c%0d]: got d_gnt=%b i_gnt=%b expected %b %b", k, d_gnt_r, i_gnt_r, exp_d, !exp_d);
        end
        tests++;
        if ({d_gnt_p, i_gnt_p} !== 2'b10) begin
          fails++;
          $display("FAIL prio_hold[c%0d]: got d_gnt=%b i_gnt=%b expected 1 0", k, d_gnt_p, i_gnt_p);
        end
      end
    end
    ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout;
    logic g, bwe, err; logic [31:0] ba, bwd, rd; logic [3:0] bbe; int rc, lat;
    run_data(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'h0, 1000, g, ba, bbe, bwe, bwd, rc, lat, rd, err);
    tests++;
    if (rc != 4) begin
      fails++;
      $display("FAIL timeout_req_cycles: got %0d expected 4", rc);
    end
    tests++;
    if (lat != 6 || err !== 1'b1 || rd !== 32'h0) begin
      fails++;
      $display("FAIL timeout_resp: got lat=%0d err=%b data=%h expected 6 1 00000000", lat, err, rd);
    end
    @(negedge clk);
    #1;
    tests++;
    if (req_p !== 1'b0) begin
      fails++;
      $display("FAIL timeout_req_after: got %b expected 0", req_p);
    end
  endtask

  task automatic test_misalign;
    logic g, bwe, err; logic [31:0] ba, bwd, rd, brd; logic [3:0] bbe; int rc, lat;
    brd = $urandom;
    run_data(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, brd, 0, g, ba, bbe, bwe, bwd, rc, lat, rd, err);
`ifdef RYSY_MISALIGN_CHECK_EN
    tests++;
    if (rc != 0 || lat != 2 || err !== 1'b1 || rd !== 32'h0) begin
      fails++;
      $display("FAIL misalign_err: got req_cycles=%0d lat=%0d err=%b data=%h expected 0 2 1 0", rc, lat, err, rd);
    end
`else
    tests++;
    if (ba !== 32'h100 || bbe !== 4'hF || lat != 2 || rd !== brd || err !== 1'b0) begin
      fails++;
      $display("FAIL misalign_forced: got addr=%h be=%h lat=%0d data=%h err=%b expected 00000100 f 2 %h 0",
               ba, bbe, lat, rd, err, brd);
    end
`endif
  endtask

  task automatic test_reset_midflight;
    logic g, bwe, err; logic [31:0] ba, rd, brd; logic [3:0] bbe; int lat;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = 32'h400; ack = 1'b0;
    #1;
    tests++;
    if (d_gnt_p !== 1'b1) begin
      fails++;
      $display("FAIL mid_gnt: got %b expected 1", d_gnt_p);
    end
    @(negedge clk);
    d_req = 1'b0;
    #1;
    tests++;
    if (req_p !== 1'b1 || be_p !== 4'hF) begin
      fails++;
      $display("FAIL mid_bus: got req=%b be=%h expected 1 f", req_p, be_p);
    end
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if (req_p !== 1'b0 || be_p !== 4'h0 || d_rvalid_p !== 1'b0 || i_rvalid_p !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: got req=%b be=%h d_rv=%b i_rv=%b expected 0 0 0 0",
               req_p, be_p, d_rvalid_p, i_rvalid_p);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      tests++;
      if (d_rvalid_p !== 1'b0 || req_p !== 1'b0) begin
        fails++;
        $display("FAIL mid_dropped[c%0d]: got d_rvalid=%b req=%b expected 0 0", k, d_rvalid_p, req_p);
      end
    end
    brd = $urandom;
    run_fetch(32'h7FC, brd, 1, g, ba, bbe, bwe, lat, rd, err);
    tests++;
    if (g !== 1'b1 || ba !== 32'h7FC || lat != 3 || rd !== brd || err !== 1'b0) begin
      fails++;
      $display("FAIL mid_fetch_after: got gnt=%b addr=%h lat=%0d data=%h err=%b expected 1 000007fc 3 %h 0",
               g, ba, lat, rd, err, brd);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random_data();
    test_fetch();
    test_priority();
    test_timeout();
    test_misalign();
    test_round_robin();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
